// File: rtl/jtframe_rst_pkg.sv
// Shared types and helpers for the jtframe reset/PLL supervisor.
package jtframe_rst_pkg;

  typedef enum logic [2:0] {
    PLL_WAIT = 3'd0,
    PLL_RST  = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    HOLD     = 3'd4,
    FAIL     = 3'd5
  } rst_st_t;

  // Bits needed for a counter that must hold values 0..limit (never narrower than 1).
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/jtframe_sync_bit.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to 0 in reset.
module jtframe_sync_bit #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  // Shift the raw input through the metastability stage into the stable stage.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared so nothing appears locked or requested out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/jtframe_rst_seq.sv
// Reset/PLL supervisor: filters PLL lock, retries a PLL that never locks,
// merges reset requests and releases the reset domains in ascending order.
module jtframe_rst_seq
  import jtframe_rst_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NOUT      = 3,
  parameter int LOCK_FILT = 16,
  parameter int PLL_HOLD  = 255,
  parameter int WAIT_TO   = 4096,
  parameter int STAGE_GAP = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pll_locked,
  output logic                         pll_rst,
  input  logic [NREQ-1:0]              rst_req,
  input  logic [NREQ-1:0]              req_mask,
  input  logic                         dwnld_busy,
  output logic [NOUT-1:0]              rst_out,
  output logic [NOUT-1:0]              rst_out_n,
  output logic                         ready,
  output logic                         fail,
  output logic [cnt_w(MAX_RETRY)-1:0]  retry_cnt
);

  localparam int LOCK_W  = cnt_w(LOCK_FILT);
  localparam int TMO_W   = cnt_w(WAIT_TO);
  localparam int HOLD_W  = cnt_w(PLL_HOLD);
  localparam int GAP_W   = cnt_w(STAGE_GAP);
  localparam int RETRY_W = cnt_w(MAX_RETRY);

  localparam logic [LOCK_W-1:0]  LOCK_MAX  = LOCK_W'(LOCK_FILT);
  localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
  localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(WAIT_TO);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(WAIT_TO - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(PLL_HOLD);
  localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(STAGE_GAP);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  // Only the last domain still in reset: the next release ends the sequence.
  localparam logic [NOUT-1:0]    TOP_ONLY  = NOUT'(1) << (NOUT - 1);

  logic            lk;
  logic [NREQ-1:0] req_sync;
  logic            req;
  logic            lk_fall;
  logic            req_rise;

  rst_st_t             state_d,     state_q;
  logic [LOCK_W-1:0]   lock_cnt_d,  lock_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_d,   tmo_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d,  hold_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_d,   gap_cnt_q;
  logic [RETRY_W-1:0]  retry_cnt_d, retry_cnt_q;
  logic [NOUT-1:0]     rst_out_d,   rst_out_q;
  logic [NOUT-1:0]     rst_out_n_d, rst_out_n_q;
  logic                pll_rst_d,   pll_rst_q;
  logic                ready_d,     ready_q;
  logic                fail_d,      fail_q;
  logic                lk_prev_d,   lk_prev_q;
  logic                req_prev_d,  req_prev_q;

  jtframe_sync_bit #(.W(1)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  jtframe_sync_bit #(.W(NREQ)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rst_req),
    .q     (req_sync)
  );

  assign req      = |(req_sync & req_mask);
  assign lk_fall  = lk_prev_q & ~lk;
  assign req_rise = req & ~req_prev_q;

  // Next-state logic for the sequencer; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    retry_cnt_d = retry_cnt_q;
    rst_out_d   = rst_out_q;
    lk_prev_d   = lk;
    req_prev_d  = req;

    case (state_q)
      PLL_WAIT: begin
        if (lk) begin
          if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
          lock_cnt_d = '0;
        end
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A lock filter completing on the timeout cycle still counts as a lock.
        if (lk && lock_cnt_q == LOCK_LAST) begin
          state_d   = RELEASE;
          gap_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          if (retry_cnt_q < RETRY_MAX) begin
            state_d     = PLL_RST;
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            hold_cnt_d  = '0;
          end else begin
            state_d = FAIL;
          end
        end
      end

      PLL_RST: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = PLL_WAIT;
          lock_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (lk_fall) begin
          state_d     = PLL_RST;
          retry_cnt_d = '0;
          hold_cnt_d  = '0;
        end else if (req) begin
          state_d = HOLD;
        end else if (gap_cnt_q == GAP_LAST) begin
          // The last domain waits for the download to finish; the gap stays saturated meanwhile.
          if (!(rst_out_q == TOP_ONLY && dwnld_busy)) begin
            rst_out_d = rst_out_q & (rst_out_q - NOUT'(1));
            gap_cnt_d = '0;
            if (rst_out_q == TOP_ONLY) state_d = RUN;
          end
        end else if (gap_cnt_q != GAP_MAX) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (lk_fall) begin
          state_d     = PLL_RST;
          retry_cnt_d = '0;
          hold_cnt_d  = '0;
        end else if (req) begin
          state_d = HOLD;
        end else if (dwnld_busy) begin
          rst_out_d[NOUT-1] = 1'b1;
          gap_cnt_d         = '0;
        end else if (rst_out_q[NOUT-1]) begin
          if (gap_cnt_q == GAP_LAST) begin
            rst_out_d[NOUT-1] = 1'b0;
            gap_cnt_d         = '0;
          end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      HOLD: begin
        if (lk_fall) begin
          state_d     = PLL_RST;
          retry_cnt_d = '0;
          hold_cnt_d  = '0;
        end else if (!req) begin
          state_d   = RELEASE;
          gap_cnt_d = '0;
        end
      end

      FAIL: begin
        // Only a fresh request (or rst_n) gives the PLL another chance.
        if (req_rise) begin
          state_d     = PLL_RST;
          retry_cnt_d = '0;
          hold_cnt_d  = '0;
        end
      end

      default: begin
        state_d = PLL_WAIT;
      end
    endcase

    if (state_d inside {PLL_WAIT, PLL_RST, HOLD, FAIL}) rst_out_d = '1;
    pll_rst_d   = (state_d == PLL_RST);
    fail_d      = (state_d == FAIL);
    ready_d     = (state_d == RUN) && (rst_out_d == '0);
    rst_out_n_d = ~rst_out_d;
  end

  // State, counters and registered outputs; rst_n aborts any sequence at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_WAIT;
      lock_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      retry_cnt_q <= '0;
      rst_out_q   <= '1;
      rst_out_n_q <= '0;
      pll_rst_q   <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lk_prev_q   <= 1'b0;
      req_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      rst_out_q   <= rst_out_d;
      rst_out_n_q <= rst_out_n_d;
      pll_rst_q   <= pll_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lk_prev_q   <= lk_prev_d;
      req_prev_q  <= req_prev_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign rst_out_n = rst_out_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Scoreboard bench for jtframe_rst_seq: a timestamp-based reference model
// predicts the outputs after every clock edge, a monitor compares them.
module tb_jtframe_rst_seq;

  localparam int NREQ      = 4;
  localparam int NOUT      = 3;
  localparam int LOCK_FILT = 4;
  localparam int PLL_HOLD  = 7;
  localparam int WAIT_TO   = 32;
  localparam int STAGE_GAP = 4;
  localparam int MAX_RETRY = 2;
  localparam int RW        = 2;

  // Model modes.
  localparam int M_WAIT  = 0;
  localparam int M_PULSE = 1;
  localparam int M_STAGE = 2;
  localparam int M_RUN   = 3;
  localparam int M_HOLD  = 4;
  localparam int M_DEAD  = 5;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic            pll_locked = 1'b0;
  logic [NREQ-1:0] rst_req    = '0;
  logic [NREQ-1:0] req_mask   = '1;
  logic            dwnld_busy = 1'b0;
  logic            pll_rst;
  logic [NOUT-1:0] rst_out;
  logic [NOUT-1:0] rst_out_n;
  logic            ready;
  logic            fail;
  logic [RW-1:0]   retry_cnt;

  typedef struct packed {
    logic [NOUT-1:0] rst_out;
    logic [NOUT-1:0] rst_out_n;
    logic            pll_rst;
    logic            ready;
    logic            fail;
    logic [RW-1:0]   retry;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  jtframe_rst_seq #(
    .NREQ      (NREQ),
    .NOUT      (NOUT),
    .LOCK_FILT (LOCK_FILT),
    .PLL_HOLD  (PLL_HOLD),
    .WAIT_TO   (WAIT_TO),
    .STAGE_GAP (STAGE_GAP),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .rst_req    (rst_req),
    .req_mask   (req_mask),
    .dwnld_busy (dwnld_busy),
    .rst_out    (rst_out),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t reset_obs();
    obs_t o;
    o.rst_out   = '1;
    o.rst_out_n = '0;
    o.pll_rst   = 1'b0;
    o.ready     = 1'b0;
    o.fail      = 1'b0;
    o.retry     = '0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.rst_out   = rst_out;
    o.rst_out_n = rst_out_n;
    o.pll_rst   = pll_rst;
    o.ready     = ready;
    o.fail      = fail;
    o.retry     = retry_cnt;
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got rst_out=%b rst_out_n=%b pll_rst=%b ready=%b fail=%b retry=%0d, want rst_out=%b rst_out_n=%b pll_rst=%b ready=%b fail=%b retry=%0d",
               name, $time, act.rst_out, act.rst_out_n, act.pll_rst, act.ready, act.fail, act.retry,
               exp.rst_out, exp.rst_out_n, exp.pll_rst, exp.ready, exp.fail, exp.retry);
    end
  endtask

  // Reference model: evaluated on every rising edge, pushes the outputs expected after it.
  initial begin : model
    int              edge_no;
    int              mode;
    int              wait_start, lock_run, pulse_start;
    int              nrel, next_rel_at, top_release_at;
    int              retries;
    bit              top_held, lk_prev, req_prev, lk, rq, go_pulse;
    bit              lk_delay[$];
    logic [NREQ-1:0] req_delay[$];
    logic [NREQ-1:0] rv;
    obs_t            e;
    edge_no = 0; mode = M_WAIT; wait_start = 0; lock_run = 0; pulse_start = 0;
    nrel = 0; next_rel_at = 0; top_release_at = 0; retries = 0;
    top_held = 0; lk_prev = 0; req_prev = 0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (!rst_n) begin
        mode = M_WAIT; wait_start = edge_no; lock_run = 0; retries = 0;
        nrel = 0; top_held = 0; lk_prev = 0; req_prev = 0;
        lk_delay  = '{1'b0, 1'b0};
        req_delay = '{4'h0, 4'h0};
      end else begin
        // Inputs become visible two edges after they are sampled.
        lk = lk_delay.pop_front();
        lk_delay.push_back(pll_locked);
        rv = req_delay.pop_front();
        req_delay.push_back(rst_req);
        rq = |(rv & req_mask);
        go_pulse = 0;
        case (mode)
          M_WAIT: begin
            lock_run = lk ? lock_run + 1 : 0;
            if (lock_run >= LOCK_FILT) begin
              mode = M_STAGE; nrel = 0; next_rel_at = edge_no + STAGE_GAP;
            end else if (edge_no - wait_start >= WAIT_TO) begin
              if (retries < MAX_RETRY) begin retries++; go_pulse = 1; end
              else mode = M_DEAD;
            end
          end
          M_PULSE: begin
            if (edge_no - pulse_start >= PLL_HOLD + 1) begin
              mode = M_WAIT; wait_start = edge_no; lock_run = 0;
            end
          end
          M_STAGE, M_RUN, M_HOLD: begin
            if (lk_prev && !lk) begin
              retries = 0; go_pulse = 1;
            end else if (mode != M_HOLD && rq) begin
              mode = M_HOLD;
            end else if (mode == M_HOLD) begin
              if (!rq) begin mode = M_STAGE; nrel = 0; next_rel_at = edge_no + STAGE_GAP; end
            end else if (mode == M_STAGE) begin
              if (edge_no == next_rel_at) begin
                if (nrel == NOUT - 1 && dwnld_busy) next_rel_at = edge_no + 1;
                else begin
                  nrel++;
                  next_rel_at = edge_no + STAGE_GAP;
                  if (nrel == NOUT) begin mode = M_RUN; top_held = 0; end
                end
              end
            end else begin
              if (dwnld_busy) begin top_held = 1; top_release_at = edge_no + STAGE_GAP; end
              else if (top_held && edge_no >= top_release_at) top_held = 0;
            end
          end
          M_DEAD: begin
            if (rq && !req_prev) begin retries = 0; go_pulse = 1; end
          end
          default: mode = M_WAIT;
        endcase
        if (go_pulse) begin mode = M_PULSE; pulse_start = edge_no; end
        lk_prev  = lk;
        req_prev = rq;
      end
      e.pll_rst = (mode == M_PULSE);
      e.fail    = (mode == M_DEAD);
      e.retry   = RW'(retries);
      if (mode == M_STAGE) e.rst_out = NOUT'(((1 << NOUT) - 1) & ~((1 << nrel) - 1));
      else if (mode == M_RUN) e.rst_out = top_held ? NOUT'(1 << (NOUT - 1)) : '0;
      else e.rst_out = '1;
      e.rst_out_n = ~e.rst_out;
      e.ready     = (mode == M_RUN) && !top_held;
      exp_q.push_back(e);
    end
  end

  // Monitor: on each falling edge compare the DUT against the oldest prediction.
  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!rst_n) e = reset_obs();
        checkOutput("outputs", dut_obs(), e);
      end
    end
  end

  task automatic applyStimulus(input bit lock, input logic [NREQ-1:0] req,
                               input logic [NREQ-1:0] mask, input bit busy, input int cycles);
    pll_locked = lock;
    rst_req    = req;
    req_mask   = mask;
    dwnld_busy = busy;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", dut_obs(), reset_obs());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", dut_obs(), reset_obs());
    pll_locked = 1'b1;
    rst_n = 1'b1;
    // Locked from reset: staged release into RUN.
    applyStimulus(1, 4'h0, 4'hF, 0, 30);
    // Lock loss in RUN, then relock.
    applyStimulus(0, 4'h0, 4'hF, 0, 4);
    applyStimulus(1, 4'h0, 4'hF, 0, 40);
    // Masked request pulses.
    applyStimulus(1, 4'b0010, 4'b0010, 0, 10);
    applyStimulus(1, 4'h0, 4'b0010, 0, 30);
    applyStimulus(1, 4'b0010, 4'h0, 0, 10);
    applyStimulus(1, 4'h0, 4'h0, 0, 10);
    // Download during release, then during RUN.
    applyStimulus(0, 4'h0, 4'hF, 0, 4);
    applyStimulus(1, 4'h0, 4'hF, 1, 40);
    applyStimulus(1, 4'h0, 4'hF, 0, 10);
    applyStimulus(1, 4'h0, 4'hF, 1, 6);
    applyStimulus(1, 4'h0, 4'hF, 0, 10);
    // PLL never locks: two retries, then give up; a request restarts it.
    pulseReset();
    applyStimulus(0, 4'h0, 4'hF, 0, 140);
    applyStimulus(0, 4'b0001, 4'hF, 0, 5);
    applyStimulus(0, 4'h0, 4'hF, 0, 10);
    applyStimulus(1, 4'h0, 4'hF, 0, 40);
    // Lock loss and request together.
    applyStimulus(0, 4'b0001, 4'hF, 0, 12);
    applyStimulus(1, 4'h0, 4'hF, 0, 40);
    // Reset in the middle of a release.
    applyStimulus(0, 4'h0, 4'hF, 0, 4);
    applyStimulus(1, 4'h0, 4'hF, 0, 20);
    pulseReset();
    applyStimulus(1, 4'h0, 4'hF, 0, 30);
    // Randomised traffic.
    for (int i = 0; i < 90; i++) begin
      bit              lock, busy;
      logic [NREQ-1:0] req, mask;
      lock = ($urandom_range(0, 9) < 8);
      req  = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      mask = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
      busy = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) pulseReset();
      applyStimulus(lock, req, mask, busy, $urandom_range(1, 40));
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
